// File: rtl/hpu_prf_wb_arb_pkg.sv
// Types shared by the PRF writeback arbiter and its MDU FIFO.
// Provides index/data/ckpt types, wb entry bundle and chk_ckpt().
package hpu_prf_wb_arb_pkg;

    localparam int PHY_SR_W = 6;
    localparam int DATA_W   = 32;
    localparam int CKPT_W   = 3;

    typedef logic [PHY_SR_W-1:0] phy_sr_index_t;
    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [CKPT_W-1:0]   ckpt_t;

    typedef struct packed {
        logic  en;
        ckpt_t ckpt;
    } update_ckpt_t;

    typedef struct packed {
        logic          en;
        phy_sr_index_t index;
    } awake_index_t;

    typedef struct packed {
        logic          vld;
        phy_sr_index_t index;
        data_t         data;
        ckpt_t         ckpt;
    } wb_entry_t;

    // True when ckpt lies in the circular window [rcov, prefet],
    // i.e. the instruction is at or after the recovery point.
    function automatic logic chk_ckpt(ckpt_t ckpt,
                                      ckpt_t rcov,
                                      ckpt_t prefet);
        ckpt_t d_c;
        ckpt_t d_p;
        d_c = ckpt - rcov;
        d_p = prefet - rcov;
        return d_c <= d_p;
    endfunction

endpackage

// File: rtl/hpu_wb_fifo.sv
// MDU writeback FIFO: single push, up to two pops, per-entry ckpt kill.
// Ports: flush/kill controls, push entry, pop count, head/head+1, count.
module hpu_wb_fifo
    import hpu_prf_wb_arb_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  update_ckpt_t     kill_i,
    input  ckpt_t            prefet_ckpt_i,
    input  logic             push_i,
    input  wb_entry_t        push_entry_i,
    input  logic [1:0]       pop_n_i,
    output wb_entry_t        head_o,
    output wb_entry_t        head1_o,
    output logic [CNT_W-1:0] count_o
);

    wb_entry_t        mem [DEPTH];
    logic [CNT_W-1:0] rd_ptr;
    logic [CNT_W-1:0] wr_ptr;
    logic [AW-1:0]    rd_a;
    logic [AW-1:0]    rd1_a;
    logic [AW-1:0]    wr_a;

    assign rd_a    = rd_ptr[AW-1:0];
    assign rd1_a   = rd_a + AW'(1);
    assign wr_a    = wr_ptr[AW-1:0];
    assign count_o = wr_ptr - rd_ptr;

    assign head_o  = (count_o != '0) ? mem[rd_a] : '0;
    assign head1_o = (count_o >= CNT_W'(2)) ? mem[rd1_a] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].vld <= 1'b0;
            end
        end else begin
            rd_ptr <= rd_ptr + CNT_W'(pop_n_i);
            // Killed entries keep their slot; they drain silently.
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_i.en &&
                    chk_ckpt(mem[i].ckpt, kill_i.ckpt,
                             prefet_ckpt_i)) begin
                    mem[i].vld <= 1'b0;
                end
            end
            if (push_i) begin
                wr_ptr     <= wr_ptr + CNT_W'(1);
                mem[wr_a]  <= push_entry_i;
            end
        end
    end

    a_cnt_le_depth: assert property (
        @(posedge clk_i) disable iff (rst_i)
        count_o <= CNT_W'(DEPTH));
    a_no_pop_empty: assert property (
        @(posedge clk_i) disable iff (rst_i)
        CNT_W'(pop_n_i) <= count_o);
    a_no_push_full: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(push_i && count_o == CNT_W'(DEPTH)));

endmodule

// File: rtl/hpu_prf_wb_arb.sv
// PRF writeback arbiter: ALU0/ALU1 own the ports, MDU fills free slots.
// Ports: ALU/MDU writebacks in, two PRF write ports and MDU awake out.
module hpu_prf_wb_arb
    import hpu_prf_wb_arb_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_en_i,
    input  update_ckpt_t     ckpt_rcov_i,
    input  ckpt_t            id__prefet_ckpt_i,
    input  logic             alu0_wb_en_i,
    input  phy_sr_index_t    alu0_wb_index_i,
    input  data_t            alu0_wb_data_i,
    input  logic             alu1_wb_en_i,
    input  phy_sr_index_t    alu1_wb_index_i,
    input  data_t            alu1_wb_data_i,
    input  logic             mdu_wb_vld_i,
    output logic             mdu_wb_rdy_o,
    input  phy_sr_index_t    mdu_wb_index_i,
    input  data_t            mdu_wb_data_i,
    input  ckpt_t            mdu_wb_ckpt_i,
    output logic             prf_wp0_en_o,
    output phy_sr_index_t    prf_wp0_index_o,
    output data_t            prf_wp0_data_o,
    output logic             prf_wp1_en_o,
    output phy_sr_index_t    prf_wp1_index_o,
    output data_t            prf_wp1_data_o,
    output awake_index_t     mdu_awake_o,
    output logic [CNT_W-1:0] mdu_left_size_o
);

    wb_entry_t        head;
    wb_entry_t        head1;
    wb_entry_t        push_entry;
    logic [CNT_W-1:0] count;
    logic [1:0]       pop_n;
    logic             free0;
    logic             free1;
    logic             have1;
    logic             have2;
    logic             kill_a;
    logic             kill_b;
    logic             kill_in;
    logic             live_a;
    logic             live_b;
    logic             wr_a;
    logic             wr_b;
    logic             wp0_fifo;
    logic             wp1_fifo;
    logic             push;

    assign free0 = !alu0_wb_en_i;
    assign free1 = !alu1_wb_en_i;
    assign have1 = count != '0;
    assign have2 = count >= CNT_W'(2);

    always_comb begin
        pop_n = 2'd0;
        unique case (1'b1)
            (free0 && free1): pop_n = have2 ? 2'd2 : {1'b0, have1};
            (free0 ^ free1):  pop_n = {1'b0, have1};
            default:          pop_n = 2'd0;
        endcase
    end

    // Entries hit by this cycle's flush/recovery are already dead.
    assign kill_a = ckpt_rcov_i.en &&
        chk_ckpt(head.ckpt, ckpt_rcov_i.ckpt, id__prefet_ckpt_i);
    assign kill_b = ckpt_rcov_i.en &&
        chk_ckpt(head1.ckpt, ckpt_rcov_i.ckpt, id__prefet_ckpt_i);
    assign live_a = head.vld && !flush_en_i && !kill_a &&
                    (head.index != '0);
    assign live_b = head1.vld && !flush_en_i && !kill_b &&
                    (head1.index != '0);

    assign wr_a = (pop_n != 2'd0) && live_a;
    assign wr_b = (pop_n == 2'd2) && live_b;

    // Head goes to the first free port, head+1 to wp1 only if both free.
    assign wp0_fifo = free0 && wr_a;
    assign wp1_fifo = free1 && (free0 ? wr_b : wr_a);

    always_comb begin
        prf_wp0_en_o    = 1'b0;
        prf_wp0_index_o = '0;
        prf_wp0_data_o  = '0;
        if (alu0_wb_en_i) begin
            prf_wp0_en_o    = 1'b1;
            prf_wp0_index_o = alu0_wb_index_i;
            prf_wp0_data_o  = alu0_wb_data_i;
        end else if (wp0_fifo) begin
            prf_wp0_en_o    = 1'b1;
            prf_wp0_index_o = head.index;
            prf_wp0_data_o  = head.data;
        end
    end

    always_comb begin
        prf_wp1_en_o    = 1'b0;
        prf_wp1_index_o = '0;
        prf_wp1_data_o  = '0;
        if (alu1_wb_en_i) begin
            prf_wp1_en_o    = 1'b1;
            prf_wp1_index_o = alu1_wb_index_i;
            prf_wp1_data_o  = alu1_wb_data_i;
        end else if (wp1_fifo) begin
            prf_wp1_en_o    = 1'b1;
            prf_wp1_index_o = free0 ? head1.index : head.index;
            prf_wp1_data_o  = free0 ? head1.data  : head.data;
        end
    end

    always_comb begin
        mdu_awake_o = '0;
        if (wr_b) begin
            mdu_awake_o = '{en: 1'b1, index: head1.index};
        end else if (wr_a) begin
            mdu_awake_o = '{en: 1'b1, index: head.index};
        end
    end

    assign kill_in = ckpt_rcov_i.en &&
        chk_ckpt(mdu_wb_ckpt_i, ckpt_rcov_i.ckpt, id__prefet_ckpt_i);
    assign mdu_wb_rdy_o    = count < CNT_W'(DEPTH);
    assign mdu_left_size_o = CNT_W'(DEPTH) - count;
    assign push = mdu_wb_vld_i && mdu_wb_rdy_o &&
                  !flush_en_i && !kill_in;

    assign push_entry = '{vld:   1'b1,
                          index: mdu_wb_index_i,
                          data:  mdu_wb_data_i,
                          ckpt:  mdu_wb_ckpt_i};

    hpu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_en_i),
        .kill_i        (ckpt_rcov_i),
        .prefet_ckpt_i (id__prefet_ckpt_i),
        .push_i        (push),
        .push_entry_i  (push_entry),
        .pop_n_i       (pop_n),
        .head_o        (head),
        .head1_o       (head1),
        .count_o       (count)
    );

    a_wp0_single: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(alu0_wb_en_i && wp0_fifo));
    a_wp1_single: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(alu1_wb_en_i && wp1_fifo));

endmodule

// File: tb/tb_hpu_prf_wb_arb.sv
// Self-checking bench for hpu_prf_wb_arb: directed cases plus random
// traffic compared against a queue-based reference model.
module tb_hpu_prf_wb_arb;
    import hpu_prf_wb_arb_pkg::*;

    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_en;
    update_ckpt_t  ckpt_rcov;
    ckpt_t         prefet_ckpt;
    logic          a0_en, a1_en;
    phy_sr_index_t a0_idx, a1_idx;
    data_t         a0_dat, a1_dat;
    logic          m_vld;
    logic          m_rdy;
    phy_sr_index_t m_idx;
    data_t         m_dat;
    ckpt_t         m_ckpt;
    logic          wp0_en, wp1_en;
    phy_sr_index_t wp0_idx, wp1_idx;
    data_t         wp0_dat, wp1_dat;
    awake_index_t  awake;
    logic [2:0]    left;

    hpu_prf_wb_arb #(.DEPTH(DEPTH)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .flush_en_i        (flush_en),
        .ckpt_rcov_i       (ckpt_rcov),
        .id__prefet_ckpt_i (prefet_ckpt),
        .alu0_wb_en_i      (a0_en),
        .alu0_wb_index_i   (a0_idx),
        .alu0_wb_data_i    (a0_dat),
        .alu1_wb_en_i      (a1_en),
        .alu1_wb_index_i   (a1_idx),
        .alu1_wb_data_i    (a1_dat),
        .mdu_wb_vld_i      (m_vld),
        .mdu_wb_rdy_o      (m_rdy),
        .mdu_wb_index_i    (m_idx),
        .mdu_wb_data_i     (m_dat),
        .mdu_wb_ckpt_i     (m_ckpt),
        .prf_wp0_en_o      (wp0_en),
        .prf_wp0_index_o   (wp0_idx),
        .prf_wp0_data_o    (wp0_dat),
        .prf_wp1_en_o      (wp1_en),
        .prf_wp1_index_o   (wp1_idx),
        .prf_wp1_data_o    (wp1_dat),
        .mdu_awake_o       (awake),
        .mdu_left_size_o   (left)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit vld;
        int idx;
        int dat;
        int ckpt;
    } m_ent_t;

    m_ent_t q[$];

    bit s_a0, s_a1, s_flush, s_rc, s_mv;
    int s_a0i, s_a0d, s_a1i, s_a1d;
    int s_rck, s_pref, s_mi, s_md, s_mc;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(string tag, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, act, exp);
    endtask

    function automatic bit m_win(int c, int r, int p);
        return ((c - r) & 7) <= ((p - r) & 7);
    endfunction

    function automatic bit m_writes(m_ent_t e);
        if (!e.vld || s_flush || e.idx == 0) return 0;
        if (s_rc && m_win(e.ckpt, s_rck, s_pref)) return 0;
        return 1;
    endfunction

    task automatic idle_stim();
        s_a0 = 0; s_a1 = 0; s_flush = 0; s_rc = 0; s_mv = 0;
        s_a0i = 0; s_a0d = 0; s_a1i = 0; s_a1d = 0;
        s_rck = 0; s_pref = 0; s_mi = 0; s_md = 0; s_mc = 0;
    endtask

    task automatic drive();
        a0_en  = s_a0;  a0_idx = phy_sr_index_t'(s_a0i);
        a0_dat = data_t'(s_a0d);
        a1_en  = s_a1;  a1_idx = phy_sr_index_t'(s_a1i);
        a1_dat = data_t'(s_a1d);
        flush_en       = s_flush;
        ckpt_rcov.en   = s_rc;
        ckpt_rcov.ckpt = ckpt_t'(s_rck);
        prefet_ckpt    = ckpt_t'(s_pref);
        m_vld  = s_mv;  m_idx = phy_sr_index_t'(s_mi);
        m_dat  = data_t'(s_md);
        m_ckpt = ckpt_t'(s_mc);
    endtask

    task automatic check_and_update();
        int  fl[2];
        int  nf, np, sz;
        bit  e_en[2];
        int  e_i[2], e_d[2];
        bit  aw_en;
        int  aw_i;
        bit  drop;
        sz = q.size();
        nf = 0;
        e_en[0] = s_a0; e_i[0] = s_a0 ? s_a0i : 0;
        e_d[0]  = s_a0 ? s_a0d : 0;
        e_en[1] = s_a1; e_i[1] = s_a1 ? s_a1i : 0;
        e_d[1]  = s_a1 ? s_a1d : 0;
        if (!s_a0) begin fl[nf] = 0; nf++; end
        if (!s_a1) begin fl[nf] = 1; nf++; end
        np = (nf < sz) ? nf : sz;
        aw_en = 0; aw_i = 0;
        for (int k = 0; k < np; k++) begin
            if (m_writes(q[k])) begin
                e_en[fl[k]] = 1;
                e_i[fl[k]]  = q[k].idx;
                e_d[fl[k]]  = q[k].dat;
                aw_en = 1;
                aw_i  = q[k].idx;
            end
        end
        check("wp0_en",  wp0_en,  e_en[0]);
        check("wp0_idx", wp0_idx, e_i[0]);
        check("wp0_dat", wp0_dat, e_d[0] & 32'hFFFF_FFFF);
        check("wp1_en",  wp1_en,  e_en[1]);
        check("wp1_idx", wp1_idx, e_i[1]);
        check("wp1_dat", wp1_dat, e_d[1] & 32'hFFFF_FFFF);
        check("awk_en",  awake.en, aw_en);
        check("awk_idx", awake.index, aw_i);
        check("rdy",     m_rdy, sz < DEPTH);
        check("left",    left, DEPTH - sz);
        for (int k = 0; k < np; k++) void'(q.pop_front());
        if (s_flush) begin
            q.delete();
        end else begin
            if (s_rc) begin
                foreach (q[k]) begin
                    if (m_win(q[k].ckpt, s_rck, s_pref)) q[k].vld = 0;
                end
            end
            drop = s_rc && m_win(s_mc, s_rck, s_pref);
            if (s_mv && sz < DEPTH && !drop)
                q.push_back('{1, s_mi, s_md, s_mc});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        #3;
        check_and_update();
    endtask

    task automatic push_busy(int idx, int dat, int ck);
        s_a0 = 1; s_a0i = 40; s_a0d = 32'h1111;
        s_a1 = 1; s_a1i = 41; s_a1d = 32'h2222;
        s_mv = 1; s_mi = idx; s_md = dat; s_mc = ck;
        step();
    endtask

    task automatic chk_rst_outs(string t);
        check({t, "_wp0en"}, wp0_en, 0);
        check({t, "_wp0i"},  wp0_idx, 0);
        check({t, "_wp0d"},  wp0_dat, 0);
        check({t, "_wp1en"}, wp1_en, 0);
        check({t, "_wp1i"},  wp1_idx, 0);
        check({t, "_wp1d"},  wp1_dat, 0);
        check({t, "_awk"},   awake, 0);
        check({t, "_rdy"},   m_rdy, 1);
        check({t, "_left"},  left, DEPTH);
    endtask

    initial begin
        rst = 1'b1;
        idle_stim();
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk_rst_outs("reset");
        rst = 1'b0;

        // T1 basic drain
        idle_stim();
        s_mv = 1; s_mi = 5; s_md = 32'hA5;
        step();
        idle_stim();
        step();
        check("t1_wp0en",  wp0_en, 1);
        check("t1_wp0i",   wp0_idx, 5);
        check("t1_wp0d",   wp0_dat, 32'hA5);
        check("t1_awk",    awake, {1'b1, 6'd5});
        step();
        check("t1_left",   left, 4);

        // T2 full back-pressure, then dual drain
        for (int i = 0; i < 4; i++) push_busy(10 + i, 100 + i, 0);
        push_busy(14, 114, 0);
        check("t2_rdy0", m_rdy, 0);
        push_busy(14, 114, 0);
        s_a0 = 0; s_a1 = 0;
        step();
        check("t2_p0", wp0_idx, 10);
        check("t2_p1", wp1_idx, 11);
        step();
        check("t2_p2", wp0_idx, 12);
        check("t2_p3", wp1_idx, 13);
        idle_stim();
        step();
        check("t2_p4", wp0_idx, 14);
        check("t2_p4d", wp0_dat, 114);

        // T3 single free slot on wp1
        push_busy(20, 200, 0);
        push_busy(21, 201, 0);
        idle_stim();
        s_a0 = 1; s_a0i = 7; s_a0d = 32'h77;
        step();
        check("t3_h0", wp1_idx, 20);
        check("t3_a0", wp0_idx, 7);
        step();
        check("t3_h1", wp1_idx, 21);
        step();
        check("t3_idle", wp1_en, 0);

        // T4 checkpoint kill
        push_busy(30, 300, 1);
        push_busy(31, 301, 2);
        push_busy(32, 302, 1);
        s_mv = 0;
        s_rc = 1; s_rck = 1; s_pref = 1;
        step();
        idle_stim();
        s_pref = 1;
        step();
        check("t4_w0", wp0_en, 0);
        check("t4_w1", wp1_idx, 31);
        step();
        check("t4_k2", wp0_en, 0);
        step();
        check("t4_left", left, 4);

        // T5 flush with queued entries and a same-cycle push
        push_busy(50, 500, 0);
        push_busy(51, 501, 0);
        push_busy(52, 502, 0);
        idle_stim();
        s_flush = 1; s_mv = 1; s_mi = 53; s_md = 503;
        step();
        check("t5_w0", wp0_en, 0);
        check("t5_w1", wp1_en, 0);
        idle_stim();
        step();
        check("t5_rdy",  m_rdy, 1);
        check("t5_left", left, 4);

        // T6 index 0, then async reset with entries queued
        idle_stim();
        s_mv = 1; s_mi = 0; s_md = 32'hDEAD;
        step();
        idle_stim();
        step();
        check("t6_z_w0", wp0_en, 0);
        check("t6_z_aw", awake.en, 0);
        push_busy(60, 600, 0);
        push_busy(61, 601, 0);
        @(posedge clk);
        #1;
        idle_stim();
        drive();
        #1;
        rst = 1'b1;
        #1;
        chk_rst_outs("t6_rst");
        q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            s_a0  = ($urandom_range(0, 99) < 45);
            s_a1  = ($urandom_range(0, 99) < 45);
            s_a0i = $urandom_range(1, 63);
            s_a0d = $urandom;
            s_a1i = $urandom_range(1, 63);
            s_a1d = $urandom;
            s_flush = ($urandom_range(0, 99) < 3);
            s_rc    = ($urandom_range(0, 99) < 6);
            s_rck   = $urandom_range(0, 7);
            s_pref  = $urandom_range(0, 7);
            s_mv    = ($urandom_range(0, 99) < 60);
            s_mi    = ($urandom_range(0, 9) == 0) ? 0
                      : $urandom_range(1, 63);
            s_md    = $urandom;
            s_mc    = $urandom_range(0, 7);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
